// File: rtl/fp32_pkg.sv
// Shared constants, state encoding and operand classification for the
// single-precision multiplier/divider datapath.
package fp32_pkg;

    localparam int FP_BIAS = 127;
    localparam int EXP_W   = 8;
    localparam int FRAC_W  = 23;
    localparam int MANT_W  = 24;

    localparam logic [31:0] QNAN = 32'h7FC0_0000;

    typedef enum logic [1:0] {
        IDLE,
        MUL,
        ROUND,
        DONE
    } state_t;

    // Classify an fp32 magnitude (sign excluded) as {is_nan, is_inf, is_zero}.
    // Denormals (exp==0, frac!=0) are reported as zero: they are flushed.
    function automatic logic [2:0] fp_class(input logic [30:0] mag);
        logic [EXP_W-1:0]  e;
        logic [FRAC_W-1:0] f;
        logic              e_max;
        e     = mag[30:FRAC_W];
        f     = mag[FRAC_W-1:0];
        e_max = (e == {EXP_W{1'b1}});
        return {e_max && (f != '0), e_max && (f == '0), e == '0};
    endfunction

endpackage

// File: rtl/fp32_round_pack.sv
// Combinational normalize / round-to-nearest-even / pack stage.
// Takes the exact 48-bit significand product, the unbiased-sum exponent
// (e1+e2-bias, 10-bit signed) and the sign; produces the packed fp32 word.
// Overflow saturates to Inf, underflow flushes to signed zero.
module fp32_round_pack
    import fp32_pkg::*;
(
    input  logic [2*MANT_W-1:0] prod_i,
    input  logic signed [9:0]   exp_i,
    input  logic                sign_i,
    output logic [31:0]         result_o
);

    logic signed [9:0]  exp_n;
    logic signed [9:0]  exp_r;
    logic [FRAC_W-1:0]  mant;
    logic [FRAC_W-1:0]  frac;
    logic [FRAC_W:0]    mant_r;
    logic               guard;
    logic               sticky;
    logic               inc;

    // Normalize on P[47], round RNE, renormalize on carry-out, then range-check.
    always_comb begin
        // NOTE: every variable gets a value before any branch so no latch is inferred.
        exp_n    = exp_i;
        mant     = prod_i[45:23];
        guard    = prod_i[22];
        sticky   = |prod_i[21:0];
        exp_r    = exp_i;
        frac     = '0;
        mant_r   = '0;
        inc      = 1'b0;
        result_o = '0;

        if (prod_i[47]) begin
            exp_n  = exp_i + 10'sd1;
            mant   = prod_i[46:24];
            guard  = prod_i[23];
            sticky = |prod_i[22:0];
        end

        inc    = guard & (sticky | mant[0]);
        mant_r = {1'b0, mant} + {{FRAC_W{1'b0}}, inc};

        if (mant_r[FRAC_W]) begin
            exp_r = exp_n + 10'sd1;
            frac  = '0;
        end else begin
            exp_r = exp_n;
            frac  = mant_r[FRAC_W-1:0];
        end

        if (exp_r >= 10'sd255) begin
            result_o = {sign_i, 8'hFF, 23'h0};
        end else if (exp_r <= 10'sd0) begin
            result_o = {sign_i, 31'h0};
        end else begin
            result_o = {sign_i, exp_r[EXP_W-1:0], frac};
        end
    end

endmodule

// File: rtl/fp32_mul_seq.sv
// Sequential IEEE-754 single-precision multiplier.
// Radix-2 shift-add significand multiply (one partial product per cycle,
// single 25-bit adder), then one cycle of RNE round/pack. Specials are
// resolved at the accept edge and skip the multiply. One op in flight.
module fp32_mul_seq
    import fp32_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in1,
    input  logic [DATA_WIDTH-1:0] in2,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out
);

    if (DATA_WIDTH != 32) begin : g_width_check
        $error("fp32_mul_seq supports only DATA_WIDTH == 32");
    end

    state_t                 state_q, state_d;
    logic [4:0]             cnt_q, cnt_d;
    logic                   sign_q, sign_d;
    logic [EXP_W-1:0]       e1_q, e1_d;
    logic [EXP_W-1:0]       e2_q, e2_d;
    logic [MANT_W-1:0]      mcand_q, mcand_d;
    logic [MANT_W-1:0]      mplier_q, mplier_d;
    logic [2*MANT_W-1:0]    acc_q, acc_d;
    logic [DATA_WIDTH-1:0]  out_q, out_d;

    logic [2:0]             cls1, cls2;
    logic                   sign_in;
    logic [MANT_W:0]        sum25;
    logic signed [9:0]      exp_unb;
    logic [31:0]            round_result;

    assign cls1    = fp_class(in1[30:0]);
    assign cls2    = fp_class(in2[30:0]);
    assign sign_in = in1[31] ^ in2[31];

    // The one adder: upper accumulator half plus (multiplier bit ? multiplicand : 0).
    assign sum25 = {1'b0, acc_q[2*MANT_W-1:MANT_W]}
                 + (mplier_q[cnt_q] ? {1'b0, mcand_q} : {(MANT_W+1){1'b0}});

    assign exp_unb = $signed({2'b00, e1_q} + {2'b00, e2_q} - 10'(FP_BIAS));

    fp32_round_pack u_round_pack (
        .prod_i   (acc_q),
        .exp_i    (exp_unb),
        .sign_i   (sign_q),
        .result_o (round_result)
    );

    assign out = out_q;

    // State and datapath registers; all cleared immediately on reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            sign_q   <= 1'b0;
            e1_q     <= '0;
            e2_q     <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            out_q    <= '0;
        end else begin
            // NOTE: non-blocking so every register samples the pre-edge values.
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            sign_q   <= sign_d;
            e1_q     <= e1_d;
            e2_q     <= e2_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            out_q    <= out_d;
        end
    end

    // Next-state, datapath next values and handshake outputs.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        sign_d    = sign_q;
        e1_d      = e1_q;
        e2_d      = e2_q;
        mcand_d   = mcand_q;
        mplier_d  = mplier_q;
        acc_d     = acc_q;
        out_d     = out_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;

        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    sign_d   = sign_in;
                    e1_d     = in1[30:FRAC_W];
                    e2_d     = in2[30:FRAC_W];
                    mcand_d  = {1'b1, in1[FRAC_W-1:0]};
                    mplier_d = {1'b1, in2[FRAC_W-1:0]};
                    acc_d    = '0;
                    cnt_d    = '0;
                    // cls = {is_nan, is_inf, is_zero}
                    if (cls1[2] || cls2[2] || (cls1[1] && cls2[0]) || (cls1[0] && cls2[1])) begin
                        out_d   = QNAN;
                        state_d = DONE;
                    end else if (cls1[1] || cls2[1]) begin
                        out_d   = {sign_in, 8'hFF, 23'h0};
                        state_d = DONE;
                    end else if (cls1[0] || cls2[0]) begin
                        out_d   = {sign_in, 31'h0};
                        state_d = DONE;
                    end else begin
                        state_d = MUL;
                    end
                end
            end
            MUL: begin
                acc_d = {sum25, acc_q[MANT_W-1:1]};
                if (cnt_q == 5'(MANT_W - 1)) begin
                    cnt_d   = '0;
                    state_d = ROUND;
                end else begin
                    cnt_d = cnt_q + 5'd1;
                end
            end
            ROUND: begin
                out_d   = round_result;
                state_d = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: doc/fp32_mul_seq.md
Name: fp32_mul_seq

Overview:
Sequential IEEE-754 single-precision multiplier. It is the companion to the combinational 24-bit mantissa divider in the floating-point datapath.
- Forms the 48-bit significand product radix-2, one partial product per cycle, using a single 25-bit adder.
- Normalizes, rounds round-to-nearest-even (RNE), packs the result.
- Valid/ready handshake on input and output; one operation in flight.

Parameters:
DATA_WIDTH, 32, operand/result width; only 32 is supported (elaboration error otherwise).

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous, active-high reset
in_valid  input  1  operands valid
in_ready  output  1  block can accept operands (high only in IDLE)
in1  input  DATA_WIDTH  multiplicand, fp32
in2  input  DATA_WIDTH  multiplier, fp32
out_valid  output  1  result valid
out_ready  input  1  consumer accepts result
out  output  DATA_WIDTH  fp32 product

Behaviour:
- Reset (async, immediate, also mid-operation): state=IDLE, out_valid=0, out=0, step counter=0, in_ready=1. All internal datapath registers are cleared.
- States: IDLE, MUL, ROUND, DONE.
- IDLE: in_ready=1. The accept edge is the edge with in_valid&in_ready. It registers sign s=in1[31]^in2[31], e1, e2, and significands {1,frac}.
- Operand classes, evaluated at the accept edge:
  - exp==255 with frac!=0 is NaN.
  - exp==255 with frac==0 is Inf.
  - exp==0 is zero; denormals are flushed to zero.
- Special results, decided at the accept edge; next state DONE, so out_valid rises 1 cycle after accept:
  - any NaN, or Inf*zero -> 32'h7FC00000 (canonical, sign 0)
  - Inf*finite or Inf*Inf -> {s,8'hFF,23'h0}
  - zero*finite -> {s,31'h0}
- Finite nonzero operands go to MUL with counter=0.
- MUL: 24 cycles, counter 0..23. Each cycle examines multiplier bit[counter] (LSB first), conditionally adds the multiplicand into the upper accumulator half, then shifts right 1. After counter 23 -> ROUND. Accumulator holds the exact 48-bit product P.
- ROUND (1 cycle), exponent in 10-bit signed: E = e1+e2-127.
  - If P[47]: E=E+1, mant=P[46:24], g=P[23], st=|P[22:0]. Else mant=P[45:23], g=P[22], st=|P[21:0].
  - Increment mant when g&(st|mant[0]). On mantissa carry-out: mant=0, E=E+1.
  - E>=255 -> {s,8'hFF,0} (overflow to Inf).
  - E<=0 -> {s,31'h0} (FTZ, no gradual underflow).
  - Else {s,E[7:0],mant}.
  - Result is registered into out; next state DONE.
- Normal-path latency: out_valid high exactly 25 cycles after the accept edge.
- DONE: out_valid=1, and out is held stable while out_ready=0 (unbounded).
  - On out_valid&out_ready: out_valid=0 at that edge, next state IDLE; out retains its last value.
  - in_ready=0 in DONE, so a back-to-back op has a one-cycle bubble.
- in_valid outside IDLE is ignored; in1/in2 changes after the accept edge have no effect.

Decomposition:
- Package fp32_pkg:
  - constants: FP_BIAS=127, EXP_W=8, FRAC_W=23, MANT_W=24, QNAN=32'h7FC00000
  - enum state_t {IDLE,MUL,ROUND,DONE}
  - function fp_class(operand) returning {is_nan,is_inf,is_zero}
- Sub-module fp32_round_pack: combinational; takes P[47:0], the E input, and s; outputs the packed fp32. It is instantiated once in the ROUND stage and reusable by the divider.

Test Plan:
1. in1=0x40400000 (3.0), in2=0x40200000 (2.5), out_ready=1 -> out=0x40F00000 (7.5); out_valid exactly 25 cycles after accept, high 1 cycle; 1.5*-2.0 (0x3FC00000, 0xC0000000) -> 0xC0400000.
2. RNE rounding: 0x3F800001*0x3F800001 -> 0x3F800002 (exact 1+2^-22+2^-46). 0x3FFFFFFF*0x3FFFFFFF -> 0x407FFFFE (mantissa renormalize, P[47]=1).
3. Range limits: 0x7F000000*0x40000000 -> 0x7F800000 (overflow). 0x00800000*0x3F000000 -> 0x00000000 (underflow FTZ). 0x80000001*0x3F800000 -> 0x80000000 (denormal flush, sign kept).
4. Specials, each with out_valid 1 cycle after accept:
   - 0x7F800000*0x00000000 -> 0x7FC00000
   - 0x7FC12345*0x3F800000 -> 0x7FC00000
   - 0xFF800000*0x40000000 -> 0xFF800000
5. Backpressure: out_ready=0 for 10 cycles after out_valid -> out stable, in_ready=0, in_valid pulses ignored. Release out_ready -> in_ready=1 next cycle; a second op completes correctly.
6. Assert rst during MUL at counter=10 -> out_valid=0 and out=0 immediately (no clock edge), in_ready=1. Deassert; 3.0*2.5 then yields 0x40F00000 with 25-cycle latency.
